// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side SRAM-like handshake signals
// shared by the port arbiter and its surroundings.
interface sram_port_arbiter_if;
  // Fetch requester
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // EXE-stage data requester
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  // Downstream memory port
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport master (
    input  inst_req, inst_addr, inst_size,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // Requesters and memory side
  modport slave (
    output inst_req, inst_addr, inst_size,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Data wins over fetch, a grant is held until its address is accepted, and an
// in-order tag FIFO steers each completion back to the requester that issued it.
module sram_port_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_port_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 err_orphan_ok
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    GRANT_OPEN = 2'd0,
    HOLD_INST  = 2'd1,
    HOLD_DATA  = 2'd2
  } grant_e;

  grant_e          state_q, state_d;
  logic [DEPTH-1:0] tags_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q;

  logic sel_data, full, mem_req_c, accept, pop, head_data, orphan;

  // Requester selection, full detection and handshake events
  always_comb begin
    sel_data  = (state_q == GRANT_OPEN) ? bus.data_req : (state_q == HOLD_DATA);
    full      = (count_q == CW'(DEPTH));
    mem_req_c = ~full & (sel_data ? bus.data_req : bus.inst_req);
    accept    = mem_req_c & bus.mem_addr_ok;
    pop       = bus.mem_data_ok & (count_q != '0);
    orphan    = bus.mem_data_ok & (count_q == '0);
    head_data = tags_q[rd_ptr_q];
  end

  // Grant state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= GRANT_OPEN;
    else         state_q <= state_d;
  end

  // Grant next-state: lock on a stalled request, release on acceptance
  always_comb begin
    state_d = state_q;
    if (mem_req_c && !bus.mem_addr_ok) begin
      state_d = sel_data ? HOLD_DATA : HOLD_INST;
    end else if (accept) begin
      state_d = GRANT_OPEN;
    end
  end

  // Downstream request mux and upstream handshake routing
  always_comb begin
    bus.mem_req      = mem_req_c;
    bus.mem_wr       = 1'b0;
    bus.mem_size     = bus.inst_size;
    bus.mem_wstrb    = 4'h0;
    bus.mem_addr     = bus.inst_addr;
    bus.mem_wdata    = 32'h0;
    if (sel_data) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_size  = bus.data_size;
      bus.mem_wstrb = bus.data_wstrb;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end
    bus.inst_addr_ok = accept & ~sel_data;
    bus.data_addr_ok = accept & sel_data;
    bus.inst_data_ok = pop & ~head_data;
    bus.data_data_ok = pop & head_data;
    bus.inst_rdata   = bus.mem_rdata;
    bus.data_rdata   = bus.mem_rdata;
    busy             = (count_q != '0);
    err_orphan_ok    = err_q;
  end

  // Outstanding count update
  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag FIFO, pointers, count and sticky orphan flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        tags_q[wr_ptr_q] <= sel_data;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (orphan) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_sram_port_arbiter;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, err_orphan_ok;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .busy          (busy),
    .err_orphan_ok (err_orphan_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner queue (1=data), held requester (-1 none), sticky error
  initial begin
    bit mq[$];
    int hold;
    bit m_err, pick_data, m_full, exp_req, acc, pop, head;
    hold  = -1;
    m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mq.delete();
        hold  = -1;
        m_err = 1'b0;
      end
      pick_data = (hold < 0) ? bit'(bus.data_req) : (hold == 1);
      m_full    = (mq.size() == DEPTH);
      exp_req   = !m_full && (pick_data ? bit'(bus.data_req) : bit'(bus.inst_req));
      acc       = exp_req && bus.mem_addr_ok;
      pop       = bus.mem_data_ok && (mq.size() > 0);
      head      = (mq.size() > 0) ? mq[0] : 1'b0;

      chk("mem_req",      32'(bus.mem_req), 32'(exp_req));
      chk("mem_addr",     bus.mem_addr,  pick_data ? bus.data_addr : bus.inst_addr);
      chk("mem_size",     32'(bus.mem_size), 32'(pick_data ? bus.data_size : bus.inst_size));
      chk("mem_wr",       32'(bus.mem_wr), 32'(pick_data ? bus.data_wr : 1'b0));
      chk("mem_wstrb",    32'(bus.mem_wstrb), 32'(pick_data ? bus.data_wstrb : 4'h0));
      chk("mem_wdata",    bus.mem_wdata, pick_data ? bus.data_wdata : 32'h0);
      chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(acc && !pick_data));
      chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(acc && pick_data));
      chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(pop && !head));
      chk("data_data_ok", 32'(bus.data_data_ok), 32'(pop && head));
      chk("inst_rdata",   bus.inst_rdata, bus.mem_rdata);
      chk("data_rdata",   bus.data_rdata, bus.mem_rdata);
      chk("busy",         32'(busy), 32'(mq.size() != 0));
      chk("err_orphan",   32'(err_orphan_ok), 32'(m_err));

      if (resetn) begin
        if (bus.mem_data_ok && mq.size() == 0) m_err = 1'b1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(pick_data);
        if (exp_req && !bus.mem_addr_ok) hold = pick_data ? 1 : 0;
        else if (acc) hold = -1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] a);
    bus.inst_req  = 1'b1;
    bus.inst_addr = a;
    bus.inst_size = 2'd2;
  endtask

  task automatic set_data(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_addr  = a;
    bus.data_size  = 2'd2;
    bus.data_wstrb = wr ? 4'hF : 4'h0;
    bus.data_wdata = wd;
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = rd;
  endtask

  initial begin
    bus.inst_req = 1'b0; bus.inst_addr = '0; bus.inst_size = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = '0;
    bus.data_wstrb = '0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;

    // Reset state
    nxt(); nxt();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_orphan_ok), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    nxt();
    resetn = 1'b1;

    // Simultaneous request: data wins, fetch granted next cycle
    set_inst(32'h1000); set_data(1'b0, 32'h2000, 32'h0); bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("sim_addr", bus.mem_addr, 32'h2000);
    chk("sim_data_aok", 32'(bus.data_addr_ok), 32'd1);
    chk("sim_inst_aok", 32'(bus.inst_addr_ok), 32'd0);
    nxt();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("sim2_addr", bus.mem_addr, 32'h1000);
    chk("sim2_inst_aok", 32'(bus.inst_addr_ok), 32'd1);
    nxt();
    idle(); respond(32'hAAAA0001);
    @(negedge clk);
    chk("sim_rsp1_data", 32'(bus.data_data_ok), 32'd1);
    chk("sim_rsp1_rdata", bus.data_rdata, 32'hAAAA0001);
    nxt();
    respond(32'hAAAA0002);
    @(negedge clk);
    chk("sim_rsp2_inst", 32'(bus.inst_data_ok), 32'd1);
    nxt();
    idle();
    @(negedge clk);
    chk("sim_idle_busy", 32'(busy), 32'd0);
    nxt();

    // Lock hold: fetch stalls three cycles while data request rises
    set_inst(32'h1100);
    @(negedge clk); chk("lock_c1", bus.mem_addr, 32'h1100); nxt();
    set_data(1'b1, 32'h2200, 32'hDEADBEEF);
    @(negedge clk); chk("lock_c2", bus.mem_addr, 32'h1100); nxt();
    @(negedge clk); chk("lock_c3", bus.mem_addr, 32'h1100); nxt();
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("lock_c4_aok", 32'(bus.inst_addr_ok), 32'd1);
    chk("lock_c4_daok", 32'(bus.data_addr_ok), 32'd0);
    nxt();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk("lock_c5_addr", bus.mem_addr, 32'h2200);
    chk("lock_c5_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("lock_c5_daok", 32'(bus.data_addr_ok), 32'd1);
    nxt();
    idle(); respond(32'h11);
    @(negedge clk); chk("lock_rsp_inst", 32'(bus.inst_data_ok), 32'd1); nxt();
    respond(32'h22);
    @(negedge clk); chk("lock_rsp_data", 32'(bus.data_data_ok), 32'd1); nxt();
    idle(); nxt();

    // Routing order: inst, data, inst
    set_inst(32'h1000); bus.mem_addr_ok = 1'b1; nxt();
    bus.inst_req = 1'b0; set_data(1'b0, 32'h2000, 32'h0); nxt();
    bus.data_req = 1'b0; set_inst(32'h1004); nxt();
    idle(); respond(32'h0000A0A0);
    @(negedge clk);
    chk("route_A_inst", 32'(bus.inst_data_ok), 32'd1);
    chk("route_A_rdata", bus.inst_rdata, 32'h0000A0A0);
    nxt();
    respond(32'h0000B0B0);
    @(negedge clk);
    chk("route_B_data", 32'(bus.data_data_ok), 32'd1);
    chk("route_B_rdata", bus.data_rdata, 32'h0000B0B0);
    nxt();
    respond(32'h0000C0C0);
    @(negedge clk); chk("route_C_inst", 32'(bus.inst_data_ok), 32'd1); nxt();
    idle(); nxt();

    // Full: four accepts, then request blocked until a completion drains one
    set_data(1'b1, 32'h3000, 32'h5A5A5A5A); bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    @(negedge clk);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_mem_req", 32'(bus.mem_req), 32'd0);
    nxt();
    respond(32'h0);
    @(negedge clk);
    chk("full_pop_mem_req", 32'(bus.mem_req), 32'd0);
    chk("full_pop_data_ok", 32'(bus.data_data_ok), 32'd1);
    nxt();
    bus.mem_data_ok = 1'b0; bus.mem_addr_ok = 1'b0;
    @(negedge clk); chk("full_resume", 32'(bus.mem_req), 32'd1); nxt();
    bus.mem_addr_ok = 1'b1; nxt();
    idle();
    for (int i = 0; i < 4; i++) begin respond(32'(i)); nxt(); end
    idle();
    @(negedge clk); chk("full_drained", 32'(busy), 32'd0); nxt();

    // Push and pop in the same cycle at count 2
    set_inst(32'h4000); bus.mem_addr_ok = 1'b1; nxt();
    bus.inst_req = 1'b0; set_data(1'b0, 32'h5000, 32'h0); nxt();
    bus.data_req = 1'b0; set_inst(32'h4004); respond(32'h77);
    @(negedge clk);
    chk("pp_inst_aok", 32'(bus.inst_addr_ok), 32'd1);
    chk("pp_inst_dok", 32'(bus.inst_data_ok), 32'd1);
    nxt();
    idle(); respond(32'h88);
    @(negedge clk); chk("pp_next_data", 32'(bus.data_data_ok), 32'd1); nxt();
    respond(32'h99);
    @(negedge clk); chk("pp_last_inst", 32'(bus.inst_data_ok), 32'd1); nxt();
    idle(); nxt();

    // Ten transactions streaming through to wrap the pointers
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i % 2 == 0) set_inst(32'h6000 + 32'(4 * i));
      else            set_data(1'b0, 32'h7000 + 32'(4 * i), 32'h0);
      bus.mem_addr_ok = 1'b1;
      if (i >= 2) respond(32'(i));
      @(negedge clk);
      if (i >= 2) chk("wrap_route", 32'(bus.data_data_ok), 32'((i - 2) % 2));
      nxt();
    end
    idle(); respond(32'hE0); nxt(); respond(32'hE1); nxt();
    idle();
    @(negedge clk); chk("wrap_drained", 32'(busy), 32'd0); nxt();

    // Orphan completion on an empty FIFO
    respond(32'hBAD0);
    @(negedge clk);
    chk("orphan_inst_dok", 32'(bus.inst_data_ok), 32'd0);
    chk("orphan_data_dok", 32'(bus.data_data_ok), 32'd0);
    nxt();
    idle();
    @(negedge clk); chk("orphan_err", 32'(err_orphan_ok), 32'd1); nxt();

    // Reset with a transaction in flight, then its late response
    set_inst(32'h8000); bus.mem_addr_ok = 1'b1; nxt();
    idle();
    @(negedge clk); chk("inflight_busy", 32'(busy), 32'd1); nxt();
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_err", 32'(err_orphan_ok), 32'd0);
    nxt();
    resetn = 1'b1;
    respond(32'hBAD1);
    @(negedge clk); chk("late_rsp_inst_dok", 32'(bus.inst_data_ok), 32'd0); nxt();
    idle();
    @(negedge clk); chk("late_rsp_err", 32'(err_orphan_ok), 32'd1); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one downstream SRAM-like memory port between the instruction-fetch requester and the EXE-stage data requester (req / addr_ok / data_ok protocol). Grants data requests over fetch requests and holds a grant stable until the address is accepted. Records the owner of each accepted transaction in an in-order tag FIFO, so that every data_ok and rdata goes back to the requester that issued it. Sits between the pipeline's inst/data sram interfaces and the memory-side bridge.

## Interface
- DEPTH, 4, maximum outstanding transactions (accepted, data_ok not yet returned); power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address
- inst_size  in  2  0:1B 1:2B 2:4B
- inst_addr_ok  out  1  fetch address accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request valid
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0:1B 1:2B 2:4B
- data_wstrb  in  4  write byte strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted this cycle
- data_data_ok  out  1  data read/write completion this cycle
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size[2], mem_wstrb[4], mem_addr[32], mem_wdata[32]  out  downstream request, same meaning as data_*
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- busy  out  1  outstanding count ≠ 0
- err_orphan_ok  out  1  sticky: mem_data_ok arrived while the FIFO was empty

## Operation
- State: lock (1b), lock_sel (1b, 1=data), tag FIFO (DEPTH×1b, rd/wr pointers), count (log2(DEPTH)+1 bits), err_orphan_ok.
- Selection, when lock=0: sel = data if data_req, else inst. When lock=1: sel = lock_sel. A requester's req is never dropped mid-wait, so lock_sel's req stays high.
- full = (count==DEPTH).
- mem_req = ~full & (sel==data ? data_req : inst_req).
- mem_* payload = selected requester's fields. For inst, mem_wr=0 and mem_wstrb=0, mem_wdata=0.
- Lock: set with lock_sel=sel when mem_req & ~mem_addr_ok. Cleared when mem_req & mem_addr_ok.
- Accept (push): mem_req & mem_addr_ok writes tag=sel at wr pointer. inst_addr_ok = accept & sel==inst. data_addr_ok = accept & sel==data.
- Completion (pop): mem_data_ok & count≠0 reads the head tag. inst_data_ok = pop & head==inst. data_data_ok = pop & head==data. Writes also complete via data_ok.
- inst_rdata = data_rdata = mem_rdata, unconditionally.
- count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Orphan: mem_data_ok with count==0 is not routed (both *_data_ok stay 0) and sets err_orphan_ok. err_orphan_ok clears only on reset.

## Timing
- Zero added latency: addr_ok and data_ok are combinational from mem_addr_ok and mem_data_ok respectively.
- mem_req depends combinationally on inst_req, data_req, lock and full. It must not depend on mem_addr_ok.
- A response never completes the request accepted in the same cycle; the downstream guarantees data_ok at least 1 cycle after addr_ok.
- Full: mem_req=0 while count==DEPTH, even if a pop occurs that cycle. Requests resume the cycle after count drops.
- Reset (async, any time including with transactions in flight): lock=0, lock_sel=0, count=0, pointers=0, err_orphan_ok=0. Outputs after reset: mem_req=0 unless a req input is high; all *_addr_ok and *_data_ok =0; busy=0. In-flight responses arriving after reset are treated as orphans.

## Test plan
- Simultaneous request: inst_req=data_req=1, mem_addr_ok=1 → mem_addr = data_addr, data_addr_ok=1, inst_addr_ok=0. Next cycle inst is granted.
- Lock hold: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 → mem_addr stays inst_addr until accepted in cycle 4; data is granted in cycle 5.
- Routing order: accept inst@0x1000, data read@0x2000, inst@0x1004. Then 3 mem_data_ok pulses with rdata A, B, C → inst_data_ok(A), data_data_ok(B), inst_data_ok(C).
- Full (DEPTH=4): 4 accepts with no data_ok → busy=1 and mem_req=0 despite data_req=1. One data_ok → mem_req=1 the following cycle.
- Push and pop in the same cycle at count=2 → count stays 2, correct tag routed. Fill and drain 10 transactions to exercise pointer wrap.
- Orphan and reset: mem_data_ok with FIFO empty → no *_data_ok, err_orphan_ok=1. Assert resetn=0 mid-transaction → count=0, busy=0, err_orphan_ok=0 immediately.
